// File: rtl/spi_top.sv
// ADS1256 SPI master (mode 1, MSB first) plus command sequencer.
// One start strobe runs a complete ADC transaction, including DRDY_L sync and t6/t11 waits.
module spi_top #(
    parameter int unsigned CLKS_PER_HALF_SCLK = 8,
    parameter int unsigned T6_CYCLES          = 650,
    parameter int unsigned T11_CYCLES         = 400
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        DRDY_L_i,
    input  logic        transaction_start_i,
    input  logic [23:0] cmd_i,
    output logic        transaction_done_o,
    input  logic        MISO_i,
    output logic        MOSI_o,
    output logic        SCLK_o,
    output logic        auto_CS_o,
    output logic        CS_L_o,
    output logic [23:0] data_o
);

    localparam int unsigned HalfW  = (CLKS_PER_HALF_SCLK > 1) ? $clog2(CLKS_PER_HALF_SCLK) : 1;
    localparam int unsigned CntMax = (T6_CYCLES > T11_CYCLES) ? T6_CYCLES : T11_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [3:0] {
        StIdle, StWaitDrdy, StSendByte, StWaitT6, StReadByte,
        StWaitT11, StRdatacWaitDrdy, StSendSdatac, StFinish
    } state_t;

    // DRDY_L synchroniser
    logic drdy_meta_q, drdy_q;
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            drdy_meta_q <= 1'b1;
            drdy_q      <= 1'b1;
        end else begin
            drdy_meta_q <= DRDY_L_i;
            drdy_q      <= drdy_meta_q;
        end
    end

    // Byte engine
    logic             eng_start;
    logic [7:0]       eng_tx;
    logic             eng_busy_q, eng_done_q, sclk_q, mosi_q;
    logic [HalfW-1:0] half_q;
    logic [2:0]       bit_q;
    logic [7:0]       tx_sr_q, rx_sr_q;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            eng_busy_q <= 1'b0;
            eng_done_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            half_q     <= '0;
            bit_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
        end else begin
            eng_done_q <= 1'b0;
            if (eng_start) begin
                eng_busy_q <= 1'b1;
                half_q     <= '0;
                bit_q      <= '0;
                sclk_q     <= 1'b0;
                tx_sr_q    <= eng_tx;
            end else if (eng_busy_q) begin
                if (half_q == HalfW'(CLKS_PER_HALF_SCLK - 1)) begin
                    half_q <= '0;
                    sclk_q <= ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: present next bit
                        mosi_q  <= tx_sr_q[7];
                        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                    end else begin
                        rx_sr_q <= {rx_sr_q[6:0], MISO_i};
                        if (bit_q == 3'd7) begin
                            eng_busy_q <= 1'b0;
                            eng_done_q <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end else begin
                    half_q <= half_q + HalfW'(1);
                end
            end
        end
    end

    assign SCLK_o    = sclk_q;
    assign MOSI_o    = mosi_q;
    assign auto_CS_o = ~eng_busy_q;

    // Sequencer
    state_t          state_q, state_d;
    logic [23:0]     cmd_q, cmd_d, data_q, data_d;
    logic [15:0]     acc_q, acc_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cs_q, cs_d, done_q, done_d;
    logic            launched_q, launched_d, wait_high_q, wait_high_d, sdatac_q, sdatac_d;

    logic [7:0] op;
    logic       op_rdatac, op_sdatac, op_rreg, op_wreg, op_selfcal, op_read;
    logic [1:0] n_tx;

    assign op         = cmd_q[23:16];
    assign op_rdatac  = (op == 8'h03);
    assign op_sdatac  = (op == 8'h0F);
    assign op_rreg    = (op[7:4] == 4'h1);
    assign op_wreg    = (op[7:4] == 4'h5);
    assign op_selfcal = (op == 8'hF0);
    assign op_read    = (op == 8'h01) || op_rdatac || op_rreg;
    assign n_tx       = op_wreg ? 2'd3 : (op_rreg ? 2'd2 : 2'd1);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cs_d        = cs_q;
        done_d      = 1'b0;
        launched_d  = launched_q;
        wait_high_d = wait_high_q;
        sdatac_d    = sdatac_q;
        eng_start   = 1'b0;
        eng_tx      = cmd_q[23:16];
        case (idx_q)
            2'd0:    eng_tx = cmd_q[23:16];
            2'd1:    eng_tx = cmd_q[15:8];
            default: eng_tx = cmd_q[7:0];
        endcase

        case (state_q)
            StIdle: begin
                if (transaction_start_i) begin
                    cmd_d       = cmd_i;
                    idx_d       = 2'd0;
                    launched_d  = 1'b0;
                    wait_high_d = 1'b0;
                    sdatac_d    = 1'b0;
                    if (cmd_i[23:16] == 8'h01 || cmd_i[23:16] == 8'h03) begin
                        state_d = StWaitDrdy;
                    end else begin
                        cs_d    = 1'b0;
                        state_d = StSendByte;
                    end
                end
            end
            StWaitDrdy: begin
                if (wait_high_q) begin
                    if (drdy_q) wait_high_d = 1'b0;
                end else if (!drdy_q) begin
                    if (op_selfcal) begin
                        state_d = StFinish;
                    end else begin
                        cs_d    = 1'b0;
                        state_d = StSendByte;
                    end
                end
            end
            StSendByte: begin
                if (!launched_q) begin
                    eng_start  = 1'b1;
                    launched_d = 1'b1;
                end else if (eng_done_q) begin
                    launched_d = 1'b0;
                    if (idx_q == n_tx - 2'd1) begin
                        idx_d = 2'd0;
                        cnt_d = '0;
                        if (op_read) begin
                            state_d = StWaitT6;
                        end else if (op_selfcal) begin
                            wait_high_d = 1'b1;
                            state_d     = StWaitDrdy;
                        end else if (op_sdatac) begin
                            state_d = StFinish;
                        end else begin
                            state_d = StWaitT11;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StWaitT6: begin
                if (cnt_q == CntW'(T6_CYCLES - 1)) state_d = StReadByte;
                else cnt_d = cnt_q + CntW'(1);
            end
            StReadByte: begin
                eng_tx = 8'h00;
                if (!launched_q) begin
                    eng_start  = 1'b1;
                    launched_d = 1'b1;
                end else if (eng_done_q) begin
                    launched_d = 1'b0;
                    acc_d      = {acc_q[7:0], rx_sr_q};
                    if (op_rreg) begin
                        data_d  = {16'h0000, rx_sr_q};
                        state_d = StFinish;
                    end else if (idx_q == 2'd2) begin
                        // Whole word lands at once so data_o never shows a partial result
                        data_d = {acc_q, rx_sr_q};
                        idx_d  = 2'd0;
                        if (op_rdatac) begin
                            wait_high_d = 1'b1;
                            state_d     = StRdatacWaitDrdy;
                        end else begin
                            state_d = StFinish;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StRdatacWaitDrdy: begin
                if (cmd_i[23:16] == 8'h0F) sdatac_d = 1'b1;
                if (wait_high_q) begin
                    if (drdy_q) wait_high_d = 1'b0;
                end else if (!drdy_q) begin
                    idx_d      = 2'd0;
                    launched_d = 1'b0;
                    if (sdatac_q || cmd_i[23:16] == 8'h0F) state_d = StSendSdatac;
                    else state_d = StReadByte;
                end
            end
            StSendSdatac: begin
                eng_tx = 8'h0F;
                if (!launched_q) begin
                    eng_start  = 1'b1;
                    launched_d = 1'b1;
                end else if (eng_done_q) begin
                    launched_d = 1'b0;
                    state_d    = StFinish;
                end
            end
            StWaitT11: begin
                if (cnt_q == CntW'(T11_CYCLES - 1)) state_d = StFinish;
                else cnt_d = cnt_q + CntW'(1);
            end
            StFinish: begin
                cs_d    = 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            data_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            cs_q        <= 1'b1;
            done_q      <= 1'b0;
            launched_q  <= 1'b0;
            wait_high_q <= 1'b0;
            sdatac_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            done_q      <= done_d;
            launched_q  <= launched_d;
            wait_high_q <= wait_high_d;
            sdatac_q    <= sdatac_d;
        end
    end

    assign CS_L_o             = cs_q;
    assign transaction_done_o = done_q;
    assign data_o             = data_q;

endmodule

// File: tb/tb_spi_top.sv
// Directed bench for spi_top: a behavioural ADS1256 slave logs MOSI and replays MISO bytes.
module tb_spi_top;

    localparam int T6  = 650;
    localparam int T11 = 400;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        DRDY_L_i = 1'b1;
    logic        transaction_start_i = 1'b0;
    logic [23:0] cmd_i = 24'h0;
    logic        MISO_i = 1'b0;
    logic        transaction_done_o, MOSI_o, SCLK_o, auto_CS_o, CS_L_o;
    logic [23:0] data_o;

    spi_top dut (
        .clock_i            (clock_i),
        .reset_i            (reset_i),
        .DRDY_L_i           (DRDY_L_i),
        .transaction_start_i(transaction_start_i),
        .cmd_i              (cmd_i),
        .transaction_done_o (transaction_done_o),
        .MISO_i             (MISO_i),
        .MOSI_o             (MOSI_o),
        .SCLK_o             (SCLK_o),
        .auto_CS_o          (auto_CS_o),
        .CS_L_o             (CS_L_o),
        .data_o             (data_o)
    );

    always #5 clock_i = ~clock_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int cs_viol = 0;
    int base_r = 0;
    int base_f = 0;
    int rise_cyc [512];
    int fall_cyc [512];
    logic mosi_bits [512];
    logic [7:0] slave_mem [16];

    always @(posedge clock_i) begin
        cyc <= cyc + 1;
        if (transaction_done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // Slave shifts out on SCLK rise; byte slot counted from the test's base
    always @(posedge SCLK_o) begin
        int rel;
        logic [3:0] slot;
        logic [2:0] bsel;
        rel = rise_cnt - base_r;
        slot = rel[6:3];
        bsel = 3'd7 - rel[2:0];
        MISO_i <= slave_mem[slot][bsel];
        rise_cyc[rise_cnt[8:0]] <= cyc;
        if (CS_L_o) cs_viol <= cs_viol + 1;
        rise_cnt <= rise_cnt + 1;
    end

    always @(negedge SCLK_o) begin
        mosi_bits[fall_cnt[8:0]] <= MOSI_o;
        fall_cyc[fall_cnt[8:0]] <= cyc;
        fall_cnt <= fall_cnt + 1;
    end

    function automatic logic [8:0] ix(int v);
        return v[8:0];
    endfunction

    function automatic logic [7:0] mosi_byte(int first);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], mosi_bits[ix(first + i)]};
        return b;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clock_i);
    endtask

    task automatic start_cmd(logic [23:0] c);
        @(negedge clock_i);
        cmd_i = c;
        transaction_start_i = 1'b1;
        @(negedge clock_i);
        transaction_start_i = 1'b0;
    endtask

    task automatic mark_base();
        base_r = rise_cnt;
        base_f = fall_cnt;
        for (int i = 0; i < 16; i++) slave_mem[i] = 8'h00;
    endtask

    task automatic wait_done(int prev, int budget, string name);
        int t = 0;
        while (done_cnt == prev && t < budget) begin
            @(posedge clock_i);
            t++;
        end
        if (done_cnt == prev) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no transaction_done_o within %0d cycles", name, budget);
        end
        @(negedge clock_i);
    endtask

    task automatic wait_falls(int target, int budget, string name);
        int t = 0;
        while ((fall_cnt - base_f) < target && t < budget) begin
            @(posedge clock_i);
            t++;
        end
        if ((fall_cnt - base_f) < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: only %0d SCLK edges, need %0d", name, fall_cnt - base_f, target);
        end
    endtask

    task automatic test_reset();
        tick(3);
        @(negedge clock_i);
        n_cmp++; if (SCLK_o !== 1'b0) begin n_bad++; $display("FAIL rst_sclk: got %b want 0", SCLK_o); end
        n_cmp++; if (MOSI_o !== 1'b0) begin n_bad++; $display("FAIL rst_mosi: got %b want 0", MOSI_o); end
        n_cmp++; if (CS_L_o !== 1'b1) begin n_bad++; $display("FAIL rst_cs: got %b want 1", CS_L_o); end
        n_cmp++; if (auto_CS_o !== 1'b1) begin n_bad++; $display("FAIL rst_acs: got %b want 1", auto_CS_o); end
        n_cmp++; if (transaction_done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", transaction_done_o); end
        n_cmp++; if (data_o !== 24'h0) begin n_bad++; $display("FAIL rst_data: got %h want 000000", data_o); end
        reset_i = 1'b1;
        tick(5);
    endtask

    task automatic test_rdata();
        int prev = done_cnt;
        mark_base();
        slave_mem[1] = 8'h12; slave_mem[2] = 8'h34; slave_mem[3] = 8'h56;
        start_cmd(24'h010000);
        tick(100);
        @(negedge clock_i);
        n_cmp++; if (rise_cnt - base_r !== 0) begin n_bad++; $display("FAIL rdata_wait: got %0d SCLKs want 0 before DRDY", rise_cnt - base_r); end
        n_cmp++; if (CS_L_o !== 1'b1) begin n_bad++; $display("FAIL rdata_cs_wait: got %b want 1", CS_L_o); end
        DRDY_L_i = 1'b0;
        wait_done(prev, 3000, "rdata_done");
        DRDY_L_i = 1'b1;
        n_cmp++; if (mosi_byte(base_f) !== 8'h01) begin n_bad++; $display("FAIL rdata_op: got %h want 01", mosi_byte(base_f)); end
        n_cmp++; if (rise_cnt - base_r !== 32) begin n_bad++; $display("FAIL rdata_sclks: got %0d want 32", rise_cnt - base_r); end
        n_cmp++; if (rise_cyc[ix(base_r + 8)] - fall_cyc[ix(base_f + 7)] < T6) begin
            n_bad++; $display("FAIL rdata_t6: got %0d want >= %0d", rise_cyc[ix(base_r + 8)] - fall_cyc[ix(base_f + 7)], T6); end
        n_cmp++; if (data_o !== 24'h123456) begin n_bad++; $display("FAIL rdata_data: got %h want 123456", data_o); end
        n_cmp++; if (CS_L_o !== 1'b1) begin n_bad++; $display("FAIL rdata_cs: got %b want 1", CS_L_o); end
        tick(20);
        n_cmp++; if (done_cnt !== prev + 1) begin n_bad++; $display("FAIL rdata_pulses: got %0d want %0d", done_cnt, prev + 1); end
    endtask

    task automatic test_rdatac();
        int prev = done_cnt;
        logic [23:0] exp_w [3];
        exp_w[0] = 24'h123456; exp_w[1] = 24'h654321; exp_w[2] = 24'hABCDEF;
        mark_base();
        for (int k = 0; k < 3; k++) begin
            slave_mem[1 + 3 * k] = exp_w[k][23:16];
            slave_mem[2 + 3 * k] = exp_w[k][15:8];
            slave_mem[3 + 3 * k] = exp_w[k][7:0];
        end
        start_cmd(24'h030000);
        for (int k = 0; k < 3; k++) begin
            tick(20);
            DRDY_L_i = 1'b0;
            tick(200);
            DRDY_L_i = 1'b1;
            wait_falls(32 + 24 * k, 3000, "rdatac_conv");
            tick(3);
            @(negedge clock_i);
            n_cmp++; if (data_o !== exp_w[k]) begin n_bad++; $display("FAIL rdatac_data%0d: got %h want %h", k, data_o, exp_w[k]); end
            n_cmp++; if (CS_L_o !== 1'b0) begin n_bad++; $display("FAIL rdatac_cs%0d: got %b want 0", k, CS_L_o); end
        end
        n_cmp++; if (mosi_byte(base_f) !== 8'h03) begin n_bad++; $display("FAIL rdatac_op: got %h want 03", mosi_byte(base_f)); end
        cmd_i = 24'h0FFFFF;
        tick(100);
        @(negedge clock_i);
        n_cmp++; if (done_cnt !== prev) begin n_bad++; $display("FAIL rdatac_early_done: got %0d want %0d", done_cnt, prev); end
        DRDY_L_i = 1'b0;
        wait_done(prev, 2000, "rdatac_done");
        DRDY_L_i = 1'b1;
        n_cmp++; if (mosi_byte(base_f + 80) !== 8'h0F) begin n_bad++; $display("FAIL rdatac_sdatac: got %h want 0F", mosi_byte(base_f + 80)); end
        n_cmp++; if (fall_cnt - base_f !== 88) begin n_bad++; $display("FAIL rdatac_sclks: got %0d want 88", fall_cnt - base_f); end
        n_cmp++; if (CS_L_o !== 1'b1) begin n_bad++; $display("FAIL rdatac_cs_end: got %b want 1", CS_L_o); end
        tick(20);
        n_cmp++; if (done_cnt !== prev + 1) begin n_bad++; $display("FAIL rdatac_pulses: got %0d want %0d", done_cnt, prev + 1); end
    endtask

    task automatic test_wreg();
        int prev = done_cnt;
        mark_base();
        start_cmd(24'h570069);
        wait_done(prev, 2000, "wreg_done");
        n_cmp++; if (mosi_byte(base_f) !== 8'h57) begin n_bad++; $display("FAIL wreg_b0: got %h want 57", mosi_byte(base_f)); end
        n_cmp++; if (mosi_byte(base_f + 8) !== 8'h00) begin n_bad++; $display("FAIL wreg_b1: got %h want 00", mosi_byte(base_f + 8)); end
        n_cmp++; if (mosi_byte(base_f + 16) !== 8'h69) begin n_bad++; $display("FAIL wreg_b2: got %h want 69", mosi_byte(base_f + 16)); end
        n_cmp++; if (rise_cnt - base_r !== 24) begin n_bad++; $display("FAIL wreg_sclks: got %0d want 24", rise_cnt - base_r); end
        n_cmp++; if (done_cyc - fall_cyc[ix(base_f + 23)] < T11) begin
            n_bad++; $display("FAIL wreg_t11: got %0d want >= %0d", done_cyc - fall_cyc[ix(base_f + 23)], T11); end
        n_cmp++; if (data_o !== 24'hABCDEF) begin n_bad++; $display("FAIL wreg_data: got %h want ABCDEF", data_o); end
    endtask

    task automatic test_rreg();
        int prev = done_cnt;
        mark_base();
        slave_mem[2] = 8'hA5;
        start_cmd(24'h170069);
        wait_done(prev, 3000, "rreg_done");
        n_cmp++; if (mosi_byte(base_f) !== 8'h17) begin n_bad++; $display("FAIL rreg_b0: got %h want 17", mosi_byte(base_f)); end
        n_cmp++; if (mosi_byte(base_f + 8) !== 8'h00) begin n_bad++; $display("FAIL rreg_b1: got %h want 00", mosi_byte(base_f + 8)); end
        n_cmp++; if (rise_cnt - base_r !== 24) begin n_bad++; $display("FAIL rreg_sclks: got %0d want 24", rise_cnt - base_r); end
        n_cmp++; if (rise_cyc[ix(base_r + 16)] - fall_cyc[ix(base_f + 15)] < T6) begin
            n_bad++; $display("FAIL rreg_t6: got %0d want >= %0d", rise_cyc[ix(base_r + 16)] - fall_cyc[ix(base_f + 15)], T6); end
        n_cmp++; if (data_o !== 24'h0000A5) begin n_bad++; $display("FAIL rreg_data: got %h want 0000A5", data_o); end
    endtask

    task automatic test_selfcal();
        int prev = done_cnt;
        int low_cyc;
        mark_base();
        start_cmd(24'hF00000);
        wait_falls(8, 500, "selfcal_byte");
        tick(100);
        @(negedge clock_i);
        n_cmp++; if (done_cnt !== prev) begin n_bad++; $display("FAIL selfcal_early: got %0d dones want %0d", done_cnt, prev); end
        n_cmp++; if (mosi_byte(base_f) !== 8'hF0) begin n_bad++; $display("FAIL selfcal_op: got %h want F0", mosi_byte(base_f)); end
        DRDY_L_i = 1'b0;
        low_cyc = cyc;
        wait_done(prev, 200, "selfcal_done");
        DRDY_L_i = 1'b1;
        n_cmp++; if (done_cyc < low_cyc) begin n_bad++; $display("FAIL selfcal_order: done at %0d want >= %0d", done_cyc, low_cyc); end
        n_cmp++; if (CS_L_o !== 1'b1) begin n_bad++; $display("FAIL selfcal_cs: got %b want 1", CS_L_o); end
    endtask

    task automatic test_busy_ignore();
        int prev = done_cnt;
        mark_base();
        start_cmd(24'h5012AB);
        tick(50);
        start_cmd(24'h0F0000);
        wait_done(prev, 2000, "busy_done");
        tick(1500);
        @(negedge clock_i);
        n_cmp++; if (done_cnt !== prev + 1) begin n_bad++; $display("FAIL busy_pulses: got %0d want %0d", done_cnt, prev + 1); end
        n_cmp++; if (rise_cnt - base_r !== 24) begin n_bad++; $display("FAIL busy_sclks: got %0d want 24", rise_cnt - base_r); end
        n_cmp++; if (mosi_byte(base_f + 8) !== 8'h12) begin n_bad++; $display("FAIL busy_b1: got %h want 12", mosi_byte(base_f + 8)); end
        n_cmp++; if (mosi_byte(base_f + 16) !== 8'hAB) begin n_bad++; $display("FAIL busy_b2: got %h want AB", mosi_byte(base_f + 16)); end
    endtask

    task automatic test_reset_mid();
        int prev = done_cnt;
        int t = 0;
        int r0;
        mark_base();
        DRDY_L_i = 1'b0;
        start_cmd(24'h010000);
        while (SCLK_o !== 1'b1 && t < 500) begin
            @(posedge clock_i);
            t++;
        end
        if (SCLK_o !== 1'b1) begin n_cmp++; n_bad++; $display("FAIL rmid_sclk_wait: SCLK_o never rose"); end
        tick(2);
        @(negedge clock_i);
        n_cmp++; if (CS_L_o !== 1'b0) begin n_bad++; $display("FAIL rmid_cs_pre: got %b want 0", CS_L_o); end
        #2 reset_i = 1'b0;
        #1;
        n_cmp++; if (SCLK_o !== 1'b0) begin n_bad++; $display("FAIL rmid_sclk: got %b want 0", SCLK_o); end
        n_cmp++; if (CS_L_o !== 1'b1) begin n_bad++; $display("FAIL rmid_cs: got %b want 1", CS_L_o); end
        n_cmp++; if (auto_CS_o !== 1'b1) begin n_bad++; $display("FAIL rmid_acs: got %b want 1", auto_CS_o); end
        n_cmp++; if (MOSI_o !== 1'b0) begin n_bad++; $display("FAIL rmid_mosi: got %b want 0", MOSI_o); end
        n_cmp++; if (data_o !== 24'h0) begin n_bad++; $display("FAIL rmid_data: got %h want 000000", data_o); end
        @(negedge clock_i);
        reset_i = 1'b1;
        r0 = rise_cnt;
        tick(300);
        @(negedge clock_i);
        n_cmp++; if (rise_cnt !== r0) begin n_bad++; $display("FAIL rmid_idle: got %0d SCLKs want 0", rise_cnt - r0); end
        n_cmp++; if (done_cnt !== prev) begin n_bad++; $display("FAIL rmid_done: got %0d want %0d", done_cnt, prev); end
        DRDY_L_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rdata();
        test_rdatac();
        test_wreg();
        test_rreg();
        test_selfcal();
        test_busy_ignore();
        n_cmp++; if (cs_viol !== 0) begin n_bad++; $display("FAIL cs_framing: %0d SCLK rises with CS_L_o high, want 0", cs_viol); end
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
